// File: rtl/phase_timer_ctrl.sv
// Phase sequencer for a shared counter: LOAD clears and loads max, RUN counts to at_max, then advances.
// Phase length is len+2 cycles; pulses are registered. No backpressure beyond the counter's at_max.
// Define PHASE_TIMER_PAUSE_EN to add a pause input that freezes the counter in RUN.
module phase_timer_ctrl #(
  parameter  int NUM_BITS   = 8,
  parameter  int NUM_PHASES = 4,
  localparam int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           repeat_en,
  input  logic [NUM_PHASES*NUM_BITS-1:0] phase_len,
  input  logic                           cnt_at_max,
`ifdef PHASE_TIMER_PAUSE_EN
  input  logic                           pause,
`endif
  output logic                           cnt_enable,
  output logic                           cnt_clear,
  output logic                           cnt_wrap,
  output logic [NUM_BITS-1:0]            cnt_max,
  output logic [PH_W-1:0]                phase,
  output logic                           busy,
  output logic                           phase_done,
  output logic                           seq_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [NUM_BITS-1:0] len_q [NUM_PHASES];
  logic                rpt_q;
  logic                pd_q, pd_d;
  logic                sd_q, sd_d;
  logic                accept;
  logic                pause_w;

`ifdef PHASE_TIMER_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      rpt_q   <= 1'b0;
      pd_q    <= 1'b0;
      sd_q    <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pd_q    <= pd_d;
      sd_q    <= sd_d;
      if (accept) begin
        rpt_q <= repeat_en;
        for (int i = 0; i < NUM_PHASES; i++) len_q[i] <= phase_len[i*NUM_BITS +: NUM_BITS];
      end
    end
  end

  // An at_max seen in RUN always completes the phase, even while paused.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pd_d    = 1'b0;
    sd_d    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (cnt_at_max) begin
          pd_d = 1'b1;
          if (phase_q != LAST_PH) begin
            phase_d = phase_q + 1'b1;
            state_d = ST_LOAD;
          end else if (rpt_q) begin
            phase_d = '0;
            state_d = ST_LOAD;
          end else begin
            sd_d    = 1'b1;
            phase_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign cnt_clear  = (state_q != ST_RUN);
  assign cnt_enable = (state_q == ST_RUN) && !cnt_at_max && !pause_w;
  assign cnt_wrap   = 1'b0;
  assign cnt_max    = (state_q == ST_IDLE) ? '0 : len_q[phase_q];
  assign phase      = phase_q;
  assign busy       = (state_q != ST_IDLE);
  assign phase_done = pd_q;
  assign seq_done   = sd_q;

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// Bench for phase_timer_ctrl with a behavioural counter_8 attached; timeline model derived from phase lengths.
module tb_phase_timer_ctrl;

  logic        tb_clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        repeat_en = 1'b0;
  logic [31:0] phase_len = '0;
  logic        cnt_at_max;
`ifdef PHASE_TIMER_PAUSE_EN
  logic        pause = 1'b0;
`endif
  logic        cnt_enable, cnt_clear, cnt_wrap;
  logic [7:0]  cnt_max;
  logic [1:0]  phase;
  logic        busy, phase_done, seq_done;
  logic [7:0]  cnt_q = '0;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  phase_timer_ctrl #(.NUM_BITS(8), .NUM_PHASES(4)) dut (
    .clk(tb_clk), .nrst(nrst), .start(start), .abort(abort), .repeat_en(repeat_en),
    .phase_len(phase_len), .cnt_at_max(cnt_at_max),
`ifdef PHASE_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .cnt_wrap(cnt_wrap), .cnt_max(cnt_max),
    .phase(phase), .busy(busy), .phase_done(phase_done), .seq_done(seq_done)
  );

  // The attached counter: clear wins, steps toward max, holds or wraps at max.
  assign cnt_at_max = (cnt_q == cnt_max);
  always_ff @(posedge tb_clk) begin
    if (cnt_clear) cnt_q <= '0;
    else if (cnt_enable) cnt_q <= (cnt_q == cnt_max) ? (cnt_wrap ? 8'd0 : cnt_q) : cnt_q + 8'd1;
  end

  typedef struct {
    logic [1:0] phase;
    logic       busy, clear, en;
    logic [7:0] max;
    logic       pd, sd, chk_ph, ab;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] lens;
    logic        rpt;
    int          sd_k;
    int          pd_n;
    int          peak;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected per-cycle outputs, cycle 0 being the first LOAD after start.
  task automatic build(input logic [31:0] lens, input logic rpt);
    exp_t e;
    int   ln;
    bit   first;
    exp_q.delete();
    first = 1'b1;
    for (int r = 0; r < (rpt ? 2 : 1); r++) begin
      for (int p = 0; p < 4; p++) begin
        ln = int'(lens[p*8 +: 8]);
        for (int j = 0; j <= ln + 1; j++) begin
          e.phase = 2'(p); e.busy = 1'b1; e.clear = (j == 0);
          e.en = (j != 0) && (j != ln + 1); e.max = 8'(ln);
          e.pd = (j == 0) && !first; e.sd = 1'b0; e.chk_ph = 1'b1; e.ab = 1'b0;
          exp_q.push_back(e);
          first = 1'b0;
        end
      end
    end
    if (rpt) begin
      e.phase = 2'd0; e.busy = 1'b1; e.clear = 1'b1; e.en = 1'b0; e.max = lens[7:0];
      e.pd = 1'b1; e.sd = 1'b0; e.chk_ph = 1'b1; e.ab = 1'b1;
    end else begin
      e.phase = 2'd0; e.busy = 1'b0; e.clear = 1'b1; e.en = 1'b0; e.max = 8'd0;
      e.pd = 1'b1; e.sd = 1'b1; e.chk_ph = 1'b0; e.ab = 1'b0;
    end
    exp_q.push_back(e);
    e.phase = 2'd0; e.busy = 1'b0; e.clear = 1'b1; e.en = 1'b0; e.max = 8'd0;
    e.pd = 1'b0; e.sd = 1'b0; e.chk_ph = rpt; e.ab = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic run_random(input logic [31:0] lens, input logic rpt);
    build(lens, rpt);
    phase_len = lens; repeat_en = rpt; start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[k]) begin
      check("rnd_ctl", {busy, cnt_clear, cnt_enable, cnt_wrap, phase_done, seq_done},
            {exp_q[k].busy, exp_q[k].clear, exp_q[k].en, 1'b0, exp_q[k].pd, exp_q[k].sd});
      check("rnd_max", cnt_max, exp_q[k].max);
      if (exp_q[k].chk_ph) check("rnd_phase", phase, exp_q[k].phase);
      start     = exp_q[k].busy ? 1'($urandom_range(0, 1)) : 1'b0;
      abort     = exp_q[k].ab;
      phase_len = $urandom;
      repeat_en = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int pdn, sdk, peak, first_pd;
    int pd_k[$];
    logic [31:0] lens;

    vecs[0] = '{32'h02050003, 1'b0, 18, 4, 5};
    vecs[1] = '{32'h01010101, 1'b1, -1, 20, 1};
    vecs[2] = '{32'h00000000, 1'b0, 8, 4, 0};
    vecs[3] = '{32'h02000107, 1'b0, 18, 4, 7};
    vecs[4] = '{32'h00000002, 1'b1, -1, 24, 2};

    // Reset held with start asserted.
    nrst = 1'b0; start = 1'b1; phase_len = 32'h01010101;
    tick(); tick();
    check("rst_ctl", {busy, cnt_clear, cnt_enable, cnt_wrap, phase_done, seq_done}, 6'b010000);
    check("rst_max", cnt_max, 8'd0);
    check("rst_phase", phase, 2'd0);
    nrst = 1'b1;
    tick();
    check("start_load", {busy, cnt_clear, cnt_enable}, 3'b110);
    check("start_load_max", cnt_max, 8'd1);
    start = 1'b0; abort = 1'b1;
    tick();
    check("abort_load", {busy, cnt_clear, phase_done, seq_done}, 4'b0100);
    abort = 1'b0;
    tick();

    // Aggregate timing table.
    foreach (vecs[v]) begin
      phase_len = vecs[v].lens; repeat_en = vecs[v].rpt; start = 1'b1;
      tick();
      start = 1'b0;
      pdn = 0; sdk = -1; peak = 0;
      for (int k = 0; k <= 60; k++) begin
        if (phase_done) pdn++;
        if (seq_done && sdk < 0) sdk = k;
        if (int'(cnt_q) > peak) peak = int'(cnt_q);
        tick();
      end
      if (vecs[v].rpt) begin
        abort = 1'b1;
        tick();
        check("tbl_abort_pd", {phase_done, seq_done}, 2'b00);
        abort = 1'b0;
      end
      check("tbl_seq_done_cycle", sdk, vecs[v].sd_k);
      check("tbl_pd_count", pdn, vecs[v].pd_n);
      check("tbl_peak", peak, vecs[v].peak);
      check("tbl_idle", busy, 1'b0);
      tick();
    end

    // Maximum length: counter holds at 255 with enable low.
    phase_len = 32'hFFFFFFFF; repeat_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; first_pd = -1;
    for (int k = 0; k <= 257; k++) begin
      if (phase_done && first_pd < 0) first_pd = k;
      if (k == 255) check("max_pre", {cnt_q, cnt_enable}, {8'd254, 1'b1});
      if (k == 256) check("max_hold", {cnt_q, cnt_enable, cnt_at_max, cnt_wrap}, {8'd255, 3'b010});
      if (k == 257) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check("max_pd_cycle", first_pd, 257);
    check("max_abort", {busy, phase_done, seq_done, phase}, 5'b00000);
    tick();

    // Start while busy, reset mid-RUN in phase 2, start+abort in IDLE.
    phase_len = 32'h03030303; repeat_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      start = (k >= 1 && k <= 3);
      if (k == 4) check("busy_start_ignored", {busy, phase}, 3'b100);
      if (k == 12) check("mid_run_ph2", {busy, cnt_clear, phase}, 4'b1010);
      if (k < 12) tick();
    end
    start = 1'b0; nrst = 1'b0;
    tick();
    check("mid_rst", {busy, cnt_clear, phase_done, seq_done, phase}, 6'b010000);
    nrst = 1'b1;
    tick();
    check("post_rst", {busy, phase_done, seq_done}, 3'b000);
    start = 1'b1; abort = 1'b1;
    tick();
    check("start_abort_idle", {busy, cnt_clear}, 2'b01);
    start = 1'b0; abort = 1'b0;
    tick();

`ifdef PHASE_TIMER_PAUSE_EN
    phase_len = 32'h04040404; repeat_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; sdk = -1; pd_k.delete();
    for (int k = 0; k <= 40; k++) begin
      pause = (k >= 8 && k <= 17);
      if (phase_done) pd_k.push_back(k);
      if (seq_done) sdk = k;
      if (k == 17) check("pause_frozen", {cnt_q, cnt_enable, phase}, {8'd1, 1'b0, 2'd1});
      tick();
    end
    pause = 1'b0;
    check("pause_pd_n", pd_k.size(), 4);
    if (pd_k.size() == 4) begin
      check("pause_pd0", pd_k[0], 6);
      check("pause_pd1", pd_k[1], 22);
      check("pause_pd2", pd_k[2], 28);
      check("pause_pd3", pd_k[3], 34);
    end
    check("pause_sd", sdk, 34);
`endif

    // Randomized sequences against the timeline model.
    for (int n = 0; n < 12; n++) begin
      lens = '0;
      for (int p = 0; p < 4; p++) lens[p*8 +: 8] = 8'($urandom_range(0, 6));
      run_random(lens, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
